// File: rtl/axis_video_reframer_if.sv
// Stream bundle around the video reframer.
//   s_axis_* : 32-bit unframed pixel input {8'h00,R,G,B} with valid/ready
//   m_axis_* : 24-bit framed video output with tuser (start-of-frame) and tlast (end-of-line)
// The reframer uses the master modport (it masters the framed video stream).
// The environment uses the slave modport.
interface axis_video_reframer_if;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tuser;
   logic        m_axis_tlast;

   modport master (
      input  s_axis_tdata,
      input  s_axis_tvalid,
      output s_axis_tready,
      output m_axis_tdata,
      output m_axis_tvalid,
      input  m_axis_tready,
      output m_axis_tuser,
      output m_axis_tlast
   );

   modport slave (
      output s_axis_tdata,
      output s_axis_tvalid,
      input  s_axis_tready,
      input  m_axis_tdata,
      input  m_axis_tvalid,
      output m_axis_tready,
      input  m_axis_tuser,
      input  m_axis_tlast
   );
endinterface

// File: rtl/axis_video_reframer.sv
// Regenerates AXI4-Stream video framing for an unframed pixel stream.
// Each accepted pixel is tagged with start-of-frame, end-of-line and end-of-frame flags
// from x/y counters, then buffered in a 2-entry FIFO. The FIFO decouples the two
// handshakes, so m_axis_tready has no combinational path to s_axis_tready.
// Ports:
//   aclk, aresetn  : clock, asynchronous active-low reset
//   axis           : stream bundle (32-bit input, 24-bit output with tuser/tlast)
//   resync         : pulse; the next accepted pixel becomes x=0,y=0
//   frame_done     : 1-cycle pulse after the handshake of a frame's last pixel
//   frame_count    : completed frames, wraps at 16 bits
module axis_video_reframer #(
   parameter int unsigned FRAME_WIDTH  = 640,
   parameter int unsigned FRAME_HEIGHT = 480,
   parameter bit          RGB_ORDER    = 1'b1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axis_video_reframer_if.master axis,
   input  logic                  resync,
   output logic                  frame_done,
   output logic [15:0]           frame_count
);

   localparam int unsigned XW    = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
   localparam int unsigned YW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
   localparam int unsigned PIX_W = 24;
   localparam int unsigned CNT_W = 2;
   localparam logic [XW-1:0]    X_LAST = XW'(FRAME_WIDTH - 1);
   localparam logic [YW-1:0]    Y_LAST = YW'(FRAME_HEIGHT - 1);
   localparam logic [XW-1:0]    X_ONE  = XW'(1);
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(2);

   // Position counters and pending resync request
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          resync_pend_q, resync_pend_d;

   // FIFO storage: pixel plus its frame tags
   logic [PIX_W-1:0] data_q [2];
   logic [PIX_W-1:0] data_d [2];
   logic             sof_q  [2];
   logic             sof_d  [2];
   logic             eol_q  [2];
   logic             eol_d  [2];
   logic             eof_q  [2];
   logic             eof_d  [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Registered output copy of the FIFO head
   logic             s_tready_q, s_tready_d;
   logic             m_tvalid_q, m_tvalid_d;
   logic [PIX_W-1:0] m_tdata_q,  m_tdata_d;
   logic             m_tuser_q,  m_tuser_d;
   logic             m_tlast_q,  m_tlast_d;
   logic             m_eof_q,    m_eof_d;
   logic             frame_done_q, frame_done_d;
   logic [15:0]      frame_count_q, frame_count_d;

   logic             accept_c;
   logic             pop_c;
   logic             pend_now_c;
   logic [PIX_W-1:0] pix_c;
   logic             tag_sof_c, tag_eol_c, tag_eof_c;
   logic             unused_pad;

   assign accept_c   = axis.s_axis_tvalid & s_tready_q;
   assign pop_c      = m_tvalid_q & axis.m_axis_tready;
   assign pend_now_c = resync_pend_q | resync;
   assign unused_pad = &{1'b0, axis.s_axis_tdata[31:24]};

   // Channel order of the outgoing pixel
   always_comb begin
      if (RGB_ORDER) begin
         pix_c = axis.s_axis_tdata[23:0];
      end else begin
         pix_c = {axis.s_axis_tdata[7:0], axis.s_axis_tdata[15:8], axis.s_axis_tdata[23:16]};
      end
   end

   // Tag the accepted pixel and advance the x/y position
   always_comb begin
      tag_sof_c     = 1'b0;
      tag_eol_c     = 1'b0;
      tag_eof_c     = 1'b0;
      x_d           = x_q;
      y_d           = y_q;
      resync_pend_d = resync_pend_q;
      if (accept_c) begin
         resync_pend_d = 1'b0;
         if (pend_now_c) begin
            // Resynced pixel is x=0,y=0; width >= 2 so it is never end-of-line
            tag_sof_c = 1'b1;
            x_d       = X_ONE;
            y_d       = '0;
         end else begin
            tag_sof_c = (x_q == '0) && (y_q == '0);
            tag_eol_c = (x_q == X_LAST);
            tag_eof_c = (x_q == X_LAST) && (y_q == Y_LAST);
            if (tag_eof_c) begin
               x_d = '0;
               y_d = '0;
            end else if (tag_eol_c) begin
               x_d = '0;
               y_d = y_q + YW'(1);
            end else begin
               x_d = x_q + XW'(1);
            end
         end
      end else if (resync) begin
         resync_pend_d = 1'b1;
      end
   end

   // FIFO update and next registered view of its head
   always_comb begin
      data_d   = data_q;
      sof_d    = sof_q;
      eol_d    = eol_q;
      eof_d    = eof_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (accept_c) begin
         data_d[wr_ptr_q] = pix_c;
         sof_d[wr_ptr_q]  = tag_sof_c;
         eol_d[wr_ptr_q]  = tag_eol_c;
         eof_d[wr_ptr_q]  = tag_eof_c;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop_c) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({accept_c, pop_c})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      s_tready_d = (cnt_d != FULL);
      m_tvalid_d = (cnt_d != '0);
      m_tdata_d  = '0;
      m_tuser_d  = 1'b0;
      m_tlast_d  = 1'b0;
      m_eof_d    = 1'b0;
      if (cnt_d != '0) begin
         m_tdata_d = data_d[rd_ptr_d];
         m_tuser_d = sof_d[rd_ptr_d];
         m_tlast_d = eol_d[rd_ptr_d];
         m_eof_d   = eof_d[rd_ptr_d];
      end

      frame_done_d  = pop_c & m_eof_q;
      frame_count_d = frame_count_q + 16'(frame_done_d);
   end

   // State registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         x_q           <= '0;
         y_q           <= '0;
         resync_pend_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            sof_q[i]  <= 1'b0;
            eol_q[i]  <= 1'b0;
            eof_q[i]  <= 1'b0;
         end
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         cnt_q         <= '0;
         s_tready_q    <= 1'b1;
         m_tvalid_q    <= 1'b0;
         m_tdata_q     <= '0;
         m_tuser_q     <= 1'b0;
         m_tlast_q     <= 1'b0;
         m_eof_q       <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         resync_pend_q <= resync_pend_d;
         data_q        <= data_d;
         sof_q         <= sof_d;
         eol_q         <= eol_d;
         eof_q         <= eof_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cnt_q         <= cnt_d;
         s_tready_q    <= s_tready_d;
         m_tvalid_q    <= m_tvalid_d;
         m_tdata_q     <= m_tdata_d;
         m_tuser_q     <= m_tuser_d;
         m_tlast_q     <= m_tlast_d;
         m_eof_q       <= m_eof_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign axis.s_axis_tready = s_tready_q;
   assign axis.m_axis_tvalid = m_tvalid_q;
   assign axis.m_axis_tdata  = m_tdata_q;
   assign axis.m_axis_tuser  = m_tuser_q;
   assign axis.m_axis_tlast  = m_tlast_q;
   assign frame_done         = frame_done_q;
   assign frame_count        = frame_count_q;

endmodule

// File: tb/tb_axis_video_reframer.sv
// Bench for axis_video_reframer with a 4x2 frame. Two instances share stimulus:
// one with RGB_ORDER=1 and one with RGB_ORDER=0.
module tb_axis_video_reframer;
   localparam int W = 4;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        m_tready = 1'b1;
   logic        resync = 1'b0;
   logic        rand_en = 1'b0;
   logic        fd1, fd0;
   logic [15:0] fc1, fc0;

   int checks = 0;
   int failures = 0;

   axis_video_reframer_if if1 ();
   axis_video_reframer_if if0 ();

   assign if1.s_axis_tdata  = s_tdata;
   assign if1.s_axis_tvalid = s_tvalid;
   assign if1.m_axis_tready = m_tready;
   assign if0.s_axis_tdata  = s_tdata;
   assign if0.s_axis_tvalid = s_tvalid;
   assign if0.m_axis_tready = m_tready;

   axis_video_reframer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .RGB_ORDER(1'b1)) dut1 (
      .aclk(clk), .aresetn(aresetn), .axis(if1), .resync(resync),
      .frame_done(fd1), .frame_count(fc1));
   axis_video_reframer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .RGB_ORDER(1'b0)) dut0 (
      .aclk(clk), .aresetn(aresetn), .axis(if0), .resync(resync),
      .frame_done(fd0), .frame_count(fc0));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: pixel index within the frame decides every tag
   typedef struct {
      logic [23:0] d1;
      logic [23:0] d0;
      logic        u;
      logic        l;
      logic        e;
   } ent_t;

   ent_t        mq[$];
   ent_t        log_q[$];
   int          p_model = 0;
   bit          pend_m = 0;
   logic [15:0] fc_m = '0;
   bit          fd_exp = 0;

   always @(negedge clk) begin
      ent_t h, n;
      bit   push, pop, pe;
      int   sz;
      if (!aresetn) begin
         mq.delete();
         p_model = 0;
         pend_m  = 0;
         fc_m    = '0;
         fd_exp  = 0;
         chk("rst_s_tready", if1.s_axis_tready, 1);
         chk("rst_m_tvalid", if1.m_axis_tvalid, 0);
         chk("rst_m_tdata",  if1.m_axis_tdata, 0);
         chk("rst_tuser",    if1.m_axis_tuser, 0);
         chk("rst_tlast",    if1.m_axis_tlast, 0);
         chk("rst_frame_done", fd1, 0);
         chk("rst_frame_count", fc1, 0);
      end else begin
         sz = mq.size();
         chk("s_tready", if1.s_axis_tready, sz < 2);
         chk("m_tvalid", if1.m_axis_tvalid, sz != 0);
         chk("m_tvalid_bgr", if0.m_axis_tvalid, sz != 0);
         if (sz != 0) begin
            chk("m_tdata_rgb", if1.m_axis_tdata, mq[0].d1);
            chk("m_tdata_bgr", if0.m_axis_tdata, mq[0].d0);
            chk("tuser", if1.m_axis_tuser, mq[0].u);
            chk("tlast", if1.m_axis_tlast, mq[0].l);
         end
         chk("frame_done", fd1, fd_exp);
         chk("frame_count", fc1, fc_m);
         pop  = (sz != 0) && m_tready;
         push = s_tvalid && (sz < 2);
         fd_exp = 0;
         if (pop) begin
            h = mq.pop_front();
            n.d1 = if1.m_axis_tdata;
            n.d0 = if0.m_axis_tdata;
            n.u  = if1.m_axis_tuser;
            n.l  = if1.m_axis_tlast;
            n.e  = 1'b0;
            log_q.push_back(n);
            if (h.e) begin
               fd_exp = 1;
               fc_m   = fc_m + 16'd1;
            end
         end
         pe = pend_m || resync;
         if (push) begin
            if (pe) p_model = 0;
            pend_m = 0;
            h.d1 = s_tdata[23:0];
            h.d0 = {s_tdata[7:0], s_tdata[15:8], s_tdata[23:16]};
            h.u  = (p_model == 0);
            h.l  = (p_model % W) == W - 1;
            h.e  = (p_model == W * H - 1);
            mq.push_back(h);
            p_model = (p_model + 1) % (W * H);
         end else begin
            pend_m = pe;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_en) begin
         #1;
         m_tready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic [31:0] d);
      int   n = 0;
      logic ok;
      s_tdata  = d;
      s_tvalid = 1'b1;
      do begin
         @(negedge clk);
         ok = if1.s_axis_tready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 200);
      s_tvalid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (mq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (mq.size() != 0) chk("drain_timeout", mq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] pix(input int i);
      return {8'h00, 8'(8'h20 + i), 8'(8'h40 + i), 8'(8'h60 + i)};
   endfunction

   initial begin
      logic [7:0] um, lm;

      // Reset
      cycles(3);
      chk("lit_rst_s_tready", if1.s_axis_tready, 1);
      chk("lit_rst_m_tdata", if1.m_axis_tdata, 0);
      aresetn = 1'b1;
      cycles(1);

      // 1/2: one full frame back-to-back, pixel 0 checks channel order
      log_q.delete();
      send(32'hAA112233);
      for (int i = 1; i < 8; i++) send(pix(i));
      drain();
      chk("t1_outputs", log_q.size(), 8);
      um = '0;
      lm = '0;
      for (int i = 0; i < 8 && i < log_q.size(); i++) begin
         um[i] = log_q[i].u;
         lm[i] = log_q[i].l;
      end
      chk("t1_tuser_mask", um, 8'h01);
      chk("t1_tlast_mask", lm, 8'h88);
      chk("t1_frame_count", fc1, 1);
      if (log_q.size() > 0) begin
         chk("t2_rgb_order1", log_q[0].d1, 24'h112233);
         chk("t2_rgb_order0", log_q[0].d0, 24'h332211);
      end

      // 3: backpressure with three offered pixels
      log_q.delete();
      m_tready = 1'b0;
      send(32'h00102030);
      send(32'h00112131);
      s_tdata  = 32'h00122232;
      s_tvalid = 1'b1;
      cycles(2);
      @(negedge clk);
      chk("t3_s_tready_full", if1.s_axis_tready, 0);
      chk("t3_hold_tvalid", if1.m_axis_tvalid, 1);
      chk("t3_hold_pixel0", if1.m_axis_tdata, 24'h102030);
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      send(32'h00122232);
      drain();
      chk("t3_outputs", log_q.size(), 3);
      if (log_q.size() == 3) begin
         chk("t3_order0", log_q[0].d1, 24'h102030);
         chk("t3_order1", log_q[1].d1, 24'h112131);
         chk("t3_order2", log_q[2].d1, 24'h122232);
      end
      for (int i = 3; i < 8; i++) send(pix(i));
      drain();
      chk("t3_frame_count", fc1, 2);

      // 4: random valid/ready over 5 frames
      log_q.delete();
      rand_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycles(int'($urandom_range(0, 2)));
         send(pix(i));
      end
      drain();
      rand_en = 1'b0;
      cycles(1);
      m_tready = 1'b1;
      cycles(2);
      chk("t4_outputs", log_q.size(), 40);
      chk("t4_frame_count", fc1, 7);

      // 5: resync after two pixels
      log_q.delete();
      send(pix(1));
      send(pix(2));
      resync = 1'b1;
      cycles(1);
      resync = 1'b0;
      for (int i = 0; i < 6; i++) send(pix(10 + i));
      drain();
      um = '0;
      lm = '0;
      for (int i = 0; i < 8 && i < log_q.size(); i++) begin
         um[i] = log_q[i].u;
         lm[i] = log_q[i].l;
      end
      chk("t5_outputs", log_q.size(), 8);
      chk("t5_tuser_mask", um, 8'h05);
      chk("t5_tlast_mask", lm, 8'h20);

      // 6: reset mid-line with the FIFO full
      m_tready = 1'b0;
      send(pix(20));
      send(pix(21));
      cycles(1);
      chk("t6_full_before_reset", if1.s_axis_tready, 0);
      aresetn = 1'b0;
      #1;
      chk("t6_rst_m_tvalid", if1.m_axis_tvalid, 0);
      chk("t6_rst_s_tready", if1.s_axis_tready, 1);
      chk("t6_rst_m_tdata", if1.m_axis_tdata, 0);
      cycles(2);
      aresetn  = 1'b1;
      m_tready = 1'b1;
      log_q.delete();
      send(pix(30));
      drain();
      chk("t6_outputs", log_q.size(), 1);
      if (log_q.size() > 0) chk("t6_tuser_after_reset", log_q[0].u, 1);
      chk("t6_frame_count", fc1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
